// File: rtl/mc_port_arbiter.sv
// mc_port_arbiter: per-core request FIFOs, round-robin grant onto one MC port, rtnctl-tagged
// response routing. Define MC_ARB_STATS_EN to enable the o_total_stalls counter.
module mc_port_arbiter #(
  parameter int NUM_CORES    = 8,
  parameter int ID_W         = 3,
  parameter int TAG_W        = 16,
  parameter int RTNCTL_WIDTH = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic [NUM_CORES-1:0]       core_rq_vld,
  input  logic [NUM_CORES*3-1:0]     core_rq_cmd,
  input  logic [NUM_CORES*4-1:0]     core_rq_scmd,
  input  logic [NUM_CORES*2-1:0]     core_rq_size,
  input  logic [NUM_CORES*48-1:0]    core_rq_vadr,
  input  logic [NUM_CORES*64-1:0]    core_rq_data,
  input  logic [NUM_CORES*TAG_W-1:0] core_rq_tag,
  output logic [NUM_CORES-1:0]       core_rq_stall,
  output logic [NUM_CORES-1:0]       core_rs_vld,
  output logic [2:0]                 core_rs_cmd,
  output logic [3:0]                 core_rs_scmd,
  output logic [63:0]                core_rs_data,
  output logic [TAG_W-1:0]           core_rs_tag,
  input  logic [NUM_CORES-1:0]       core_rs_stall,
  output logic                       mc_rq_vld,
  output logic [2:0]                 mc_rq_cmd,
  output logic [3:0]                 mc_rq_scmd,
  output logic [1:0]                 mc_rq_size,
  output logic [47:0]                mc_rq_vadr,
  output logic [63:0]                mc_rq_data,
  output logic [RTNCTL_WIDTH-1:0]    mc_rq_rtnctl,
  input  logic                       mc_rq_stall,
  input  logic                       mc_rs_vld,
  input  logic [2:0]                 mc_rs_cmd,
  input  logic [3:0]                 mc_rs_scmd,
  input  logic [63:0]                mc_rs_data,
  input  logic [RTNCTL_WIDTH-1:0]    mc_rs_rtnctl,
  output logic                       mc_rs_stall,
  output logic                       o_err_bad_id,
  output logic [63:0]                o_total_stalls
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + 121;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] SKID_C  = CNT_W'(FIFO_DEPTH - 2);

  logic [ENT_W-1:0]        head [NUM_CORES];
  logic [NUM_CORES-1:0]    nonempty;
  logic                    grant_vld;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W-1:0]         idx;
  logic [ID_W-1:0]         last_reg;
  logic                    st_vld_reg;
  logic [ID_W-1:0]         st_id_reg;
  logic [ENT_W-1:0]        st_ent_reg;
  logic [RTNCTL_WIDTH-1:0] rtnctl_next;

  logic                    rq_vld_reg;
  logic [2:0]              rq_cmd_reg;
  logic [3:0]              rq_scmd_reg;
  logic [1:0]              rq_size_reg;
  logic [47:0]             rq_vadr_reg;
  logic [63:0]             rq_data_reg;
  logic [RTNCTL_WIDTH-1:0] rq_rtnctl_reg;

  // Entry layout, MSB first: cmd, scmd, size, vadr, data, tag
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_fifo
      logic [ENT_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             stall_reg;
      logic             push, pop;
      logic [ENT_W-1:0] wr_ent;

      assign pop    = grant_vld && (grant_id == ID_W'(gi));
      assign push   = core_rq_vld[gi] && ((count_reg < DEPTH_C) || pop);
      assign wr_ent = {core_rq_cmd[gi*3 +: 3], core_rq_scmd[gi*4 +: 4], core_rq_size[gi*2 +: 2],
                       core_rq_vadr[gi*48 +: 48], core_rq_data[gi*64 +: 64],
                       core_rq_tag[gi*TAG_W +: TAG_W]};
      assign head[gi]          = mem[rd_ptr_reg];
      assign nonempty[gi]      = (count_reg != '0);
      assign core_rq_stall[gi] = stall_reg;

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_ent;
      end

      always_ff @(posedge clk) begin
        if (i_reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          stall_reg  <= 1'b0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
          // Two entries of headroom absorb the core's reaction to a registered stall
          stall_reg <= (count_reg >= SKID_C);
        end
      end
    end
  endgenerate

  // Walk from last+NUM_CORES down to last+1 so the nearest non-empty FIFO after last wins
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      idx = last_reg + ID_W'(k);
      if (nonempty[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    if (mc_rq_stall) grant_vld = 1'b0;
  end

  always_comb begin
    rtnctl_next                = '0;
    rtnctl_next[TAG_W-1:0]     = st_ent_reg[TAG_W-1:0];
    rtnctl_next[TAG_W +: ID_W] = st_id_reg;
  end

  // Grant stage holds its entry while the MC stalls, so nothing granted is ever lost
  always_ff @(posedge clk) begin
    if (i_reset) begin
      last_reg      <= ID_W'(NUM_CORES - 1);
      st_vld_reg    <= 1'b0;
      st_id_reg     <= '0;
      st_ent_reg    <= '0;
      rq_vld_reg    <= 1'b0;
      rq_cmd_reg    <= '0;
      rq_scmd_reg   <= '0;
      rq_size_reg   <= '0;
      rq_vadr_reg   <= '0;
      rq_data_reg   <= '0;
      rq_rtnctl_reg <= '0;
    end else if (mc_rq_stall) begin
      rq_vld_reg <= 1'b0;
    end else begin
      rq_vld_reg <= st_vld_reg;
      if (st_vld_reg) begin
        rq_cmd_reg    <= st_ent_reg[TAG_W+118 +: 3];
        rq_scmd_reg   <= st_ent_reg[TAG_W+114 +: 4];
        rq_size_reg   <= st_ent_reg[TAG_W+112 +: 2];
        rq_vadr_reg   <= st_ent_reg[TAG_W+64 +: 48];
        rq_data_reg   <= st_ent_reg[TAG_W +: 64];
        rq_rtnctl_reg <= rtnctl_next;
      end
      st_vld_reg <= grant_vld;
      if (grant_vld) begin
        st_ent_reg <= head[grant_id];
        st_id_reg  <= grant_id;
        last_reg   <= grant_id;
      end
    end
  end

  assign mc_rq_vld    = rq_vld_reg;
  assign mc_rq_cmd    = rq_cmd_reg;
  assign mc_rq_scmd   = rq_scmd_reg;
  assign mc_rq_size   = rq_size_reg;
  assign mc_rq_vadr   = rq_vadr_reg;
  assign mc_rq_data   = rq_data_reg;
  assign mc_rq_rtnctl = rq_rtnctl_reg;

  // Any bit set above the id field means an id beyond NUM_CORES-1
  logic [ID_W-1:0]         rs_id;
  logic [RTNCTL_WIDTH-1:0] rs_upper;
  logic                    rs_bad;
  logic [NUM_CORES-1:0]    rs_vld_reg;
  logic [2:0]              rs_cmd_reg;
  logic [3:0]              rs_scmd_reg;
  logic [63:0]             rs_data_reg;
  logic [TAG_W-1:0]        rs_tag_reg;
  logic                    rs_stall_reg;
  logic                    err_reg;

  assign rs_id    = mc_rs_rtnctl[TAG_W +: ID_W];
  assign rs_upper = mc_rs_rtnctl >> (TAG_W + ID_W);
  assign rs_bad   = |rs_upper;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rs_vld_reg   <= '0;
      rs_cmd_reg   <= '0;
      rs_scmd_reg  <= '0;
      rs_data_reg  <= '0;
      rs_tag_reg   <= '0;
      rs_stall_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rs_vld_reg <= '0;
      if (mc_rs_vld && !rs_bad) begin
        rs_vld_reg[rs_id] <= 1'b1;
        rs_cmd_reg        <= mc_rs_cmd;
        rs_scmd_reg       <= mc_rs_scmd;
        rs_data_reg       <= mc_rs_data;
        rs_tag_reg        <= mc_rs_rtnctl[TAG_W-1:0];
      end
      if (mc_rs_vld && rs_bad) err_reg <= 1'b1;
      rs_stall_reg <= |core_rs_stall;
    end
  end

  assign core_rs_vld  = rs_vld_reg;
  assign core_rs_cmd  = rs_cmd_reg;
  assign core_rs_scmd = rs_scmd_reg;
  assign core_rs_data = rs_data_reg;
  assign core_rs_tag  = rs_tag_reg;
  assign mc_rs_stall  = rs_stall_reg;
  assign o_err_bad_id = err_reg;

`ifdef MC_ARB_STATS_EN
  logic [63:0] stalls_reg;
  always_ff @(posedge clk) begin
    if (i_reset)
      stalls_reg <= '0;
    else if (mc_rq_stall && (|nonempty) && (stalls_reg != '1))
      stalls_reg <= stalls_reg + 64'd1;
  end
  assign o_total_stalls = stalls_reg;
`else
  assign o_total_stalls = 64'd0;
`endif

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Bench for mc_port_arbiter: queue-based reference model for the 8-core instance plus
// directed literal checks on it and on a 4-core instance (bad id, reset flush).
module tb_mc_port_arbiter;
  localparam int N  = 8;
  localparam int TW = 16;
  localparam int D  = 4;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [1:0]  size;
    logic [47:0] vadr;
    logic [63:0] data;
    logic [15:0] tag;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-core instance ----------------
  logic i_reset = 1'b1;
  logic [N-1:0] core_rq_vld, core_rq_stall, core_rs_vld, core_rs_stall;
  logic [N*3-1:0] core_rq_cmd;
  logic [N*4-1:0] core_rq_scmd;
  logic [N*2-1:0] core_rq_size;
  logic [N*48-1:0] core_rq_vadr;
  logic [N*64-1:0] core_rq_data;
  logic [N*TW-1:0] core_rq_tag;
  logic [2:0] core_rs_cmd, mc_rq_cmd, mc_rs_cmd;
  logic [3:0] core_rs_scmd, mc_rq_scmd, mc_rs_scmd;
  logic [63:0] core_rs_data, mc_rq_data, mc_rs_data, o_total_stalls;
  logic [TW-1:0] core_rs_tag;
  logic mc_rq_vld, mc_rq_stall, mc_rs_vld, mc_rs_stall, o_err_bad_id;
  logic [1:0] mc_rq_size;
  logic [47:0] mc_rq_vadr;
  logic [31:0] mc_rq_rtnctl, mc_rs_rtnctl;

  mc_port_arbiter dut (
    .clk(clk), .i_reset(i_reset),
    .core_rq_vld(core_rq_vld), .core_rq_cmd(core_rq_cmd), .core_rq_scmd(core_rq_scmd),
    .core_rq_size(core_rq_size), .core_rq_vadr(core_rq_vadr), .core_rq_data(core_rq_data),
    .core_rq_tag(core_rq_tag), .core_rq_stall(core_rq_stall),
    .core_rs_vld(core_rs_vld), .core_rs_cmd(core_rs_cmd), .core_rs_scmd(core_rs_scmd),
    .core_rs_data(core_rs_data), .core_rs_tag(core_rs_tag), .core_rs_stall(core_rs_stall),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd), .mc_rq_size(mc_rq_size),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd), .mc_rs_data(mc_rs_data),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
    .o_err_bad_id(o_err_bad_id), .o_total_stalls(o_total_stalls)
  );

  // ---------------- 4-core instance ----------------
  logic f_reset = 1'b1;
  logic [3:0] f_core_rq_vld, f_core_rq_stall, f_core_rs_vld, f_core_rs_stall;
  logic [11:0] f_core_rq_cmd;
  logic [15:0] f_core_rq_scmd;
  logic [7:0] f_core_rq_size;
  logic [191:0] f_core_rq_vadr;
  logic [255:0] f_core_rq_data;
  logic [63:0] f_core_rq_tag;
  logic [2:0] f_core_rs_cmd, f_mc_rq_cmd, f_mc_rs_cmd;
  logic [3:0] f_core_rs_scmd, f_mc_rq_scmd, f_mc_rs_scmd;
  logic [63:0] f_core_rs_data, f_mc_rq_data, f_mc_rs_data, f_o_total_stalls;
  logic [TW-1:0] f_core_rs_tag;
  logic f_mc_rq_vld, f_mc_rq_stall, f_mc_rs_vld, f_mc_rs_stall, f_o_err_bad_id;
  logic [1:0] f_mc_rq_size;
  logic [47:0] f_mc_rq_vadr;
  logic [31:0] f_mc_rq_rtnctl, f_mc_rs_rtnctl;

  mc_port_arbiter #(.NUM_CORES(4), .ID_W(2)) dut4 (
    .clk(clk), .i_reset(f_reset),
    .core_rq_vld(f_core_rq_vld), .core_rq_cmd(f_core_rq_cmd), .core_rq_scmd(f_core_rq_scmd),
    .core_rq_size(f_core_rq_size), .core_rq_vadr(f_core_rq_vadr), .core_rq_data(f_core_rq_data),
    .core_rq_tag(f_core_rq_tag), .core_rq_stall(f_core_rq_stall),
    .core_rs_vld(f_core_rs_vld), .core_rs_cmd(f_core_rs_cmd), .core_rs_scmd(f_core_rs_scmd),
    .core_rs_data(f_core_rs_data), .core_rs_tag(f_core_rs_tag), .core_rs_stall(f_core_rs_stall),
    .mc_rq_vld(f_mc_rq_vld), .mc_rq_cmd(f_mc_rq_cmd), .mc_rq_scmd(f_mc_rq_scmd),
    .mc_rq_size(f_mc_rq_size), .mc_rq_vadr(f_mc_rq_vadr), .mc_rq_data(f_mc_rq_data),
    .mc_rq_rtnctl(f_mc_rq_rtnctl), .mc_rq_stall(f_mc_rq_stall),
    .mc_rs_vld(f_mc_rs_vld), .mc_rs_cmd(f_mc_rs_cmd), .mc_rs_scmd(f_mc_rs_scmd),
    .mc_rs_data(f_mc_rs_data), .mc_rs_rtnctl(f_mc_rs_rtnctl), .mc_rs_stall(f_mc_rs_stall),
    .o_err_bad_id(f_o_err_bad_id), .o_total_stalls(f_o_total_stalls)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input int c, input logic [15:0] t);
    req_t r;
    r.cmd  = 3'(c + 1);
    r.scmd = t[3:0];
    r.size = 2'd3;
    r.vadr = {24'h0, 8'(c), t};
    r.data = {32'hC0DE_0000 | 32'(c), 16'h0, t};
    r.tag  = t;
    return r;
  endfunction

  task automatic push8(input int c, input logic [15:0] t);
    req_t r;
    r = mk_req(c, t);
    core_rq_vld[c] = 1'b1;
    core_rq_cmd[c*3 +: 3] = r.cmd;
    core_rq_scmd[c*4 +: 4] = r.scmd;
    core_rq_size[c*2 +: 2] = r.size;
    core_rq_vadr[c*48 +: 48] = r.vadr;
    core_rq_data[c*64 +: 64] = r.data;
    core_rq_tag[c*TW +: TW] = r.tag;
  endtask

  task automatic push4(input int c, input logic [15:0] t);
    req_t r;
    r = mk_req(c, t);
    f_core_rq_vld[c] = 1'b1;
    f_core_rq_cmd[c*3 +: 3] = r.cmd;
    f_core_rq_scmd[c*4 +: 4] = r.scmd;
    f_core_rq_size[c*2 +: 2] = r.size;
    f_core_rq_vadr[c*48 +: 48] = r.vadr;
    f_core_rq_data[c*64 +: 64] = r.data;
    f_core_rq_tag[c*TW +: TW] = r.tag;
  endtask

  // ---------------- reference model (8-core instance) ----------------
  req_t mq [N][$];
  int m_last;
  bit m_st_vld;
  req_t m_st;
  int m_st_id;
  bit e_vld;
  req_t e_req;
  int e_id;
  logic [N-1:0] e_rq_stall, e_rs_vld;
  logic [2:0] e_rs_cmd;
  logic [3:0] e_rs_scmd;
  logic [63:0] e_rs_data;
  logic [15:0] e_rs_tag;
  bit e_err, e_rs_stall;
  longint unsigned e_stalls;
  bit model_on = 0;

  always @(posedge clk) begin
    bit any;
    int c;
    req_t r;
    if (i_reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_last = N - 1; m_st_vld = 0; e_vld = 0;
      e_rq_stall = '0; e_rs_vld = '0; e_rs_cmd = '0; e_rs_scmd = '0; e_rs_data = '0; e_rs_tag = '0;
      e_err = 0; e_rs_stall = 0; e_stalls = 0;
    end else begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (mq[i].size() > 0) any = 1;
        e_rq_stall[i] = (mq[i].size() >= D - 2);
      end
      if (mc_rq_stall) begin
        e_vld = 0;
        if (any) e_stalls++;
      end else begin
        e_vld = m_st_vld;
        if (m_st_vld) begin e_req = m_st; e_id = m_st_id; end
        m_st_vld = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!m_st_vld && mq[c].size() > 0) begin
            m_st = mq[c].pop_front(); m_st_id = c; m_st_vld = 1; m_last = c;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (core_rq_vld[i] && mq[i].size() < D) begin
          r.cmd = core_rq_cmd[i*3 +: 3]; r.scmd = core_rq_scmd[i*4 +: 4];
          r.size = core_rq_size[i*2 +: 2]; r.vadr = core_rq_vadr[i*48 +: 48];
          r.data = core_rq_data[i*64 +: 64]; r.tag = core_rq_tag[i*TW +: TW];
          mq[i].push_back(r);
        end
      end
      e_rs_vld = '0;
      if (mc_rs_vld) begin
        if (int'(mc_rs_rtnctl[31:16]) < N) begin
          e_rs_vld[mc_rs_rtnctl[31:16]] = 1'b1;
          e_rs_cmd = mc_rs_cmd; e_rs_scmd = mc_rs_scmd; e_rs_data = mc_rs_data;
          e_rs_tag = mc_rs_rtnctl[15:0];
        end else e_err = 1;
      end
      e_rs_stall = |core_rs_stall;
    end
    model_on = 1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("mc_rq_vld", mc_rq_vld, e_vld);
      if (e_vld) begin
        check("mc_rq_rtnctl", mc_rq_rtnctl, 64'(e_id) * 65536 + 64'(e_req.tag));
        check("mc_rq_vadr", mc_rq_vadr, e_req.vadr);
        check("mc_rq_data", mc_rq_data, e_req.data);
        check("mc_rq_cmd_scmd_size", {mc_rq_cmd, mc_rq_scmd, mc_rq_size},
              {e_req.cmd, e_req.scmd, e_req.size});
      end
      check("core_rq_stall", core_rq_stall, e_rq_stall);
      check("core_rs_vld", core_rs_vld, e_rs_vld);
      check("core_rs_fields", {core_rs_cmd, core_rs_scmd, core_rs_tag}, {e_rs_cmd, e_rs_scmd, e_rs_tag});
      check("core_rs_data", core_rs_data, e_rs_data);
      check("mc_rs_stall", mc_rs_stall, e_rs_stall);
      check("o_err_bad_id", o_err_bad_id, e_err);
`ifdef MC_ARB_STATS_EN
      check("o_total_stalls", o_total_stalls, e_stalls);
`else
      check("o_total_stalls", o_total_stalls, 64'd0);
`endif
    end
  end

  // ---------------- grant loggers ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;
  int log_cyc[$];
  logic [31:0] log_rt[$];
  logic [31:0] f_log_rt[$];
  always @(negedge clk) begin
    if (mc_rq_vld) begin log_cyc.push_back(cyc); log_rt.push_back(mc_rq_rtnctl); end
    if (f_mc_rq_vld) f_log_rt.push_back(f_mc_rq_rtnctl);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int k;
    core_rq_vld = '0; core_rq_cmd = '0; core_rq_scmd = '0; core_rq_size = '0;
    core_rq_vadr = '0; core_rq_data = '0; core_rq_tag = '0; core_rs_stall = '0;
    mc_rq_stall = 0; mc_rs_vld = 0; mc_rs_cmd = '0; mc_rs_scmd = '0; mc_rs_data = '0; mc_rs_rtnctl = '0;
    f_core_rq_vld = '0; f_core_rq_cmd = '0; f_core_rq_scmd = '0; f_core_rq_size = '0;
    f_core_rq_vadr = '0; f_core_rq_data = '0; f_core_rq_tag = '0; f_core_rs_stall = '0;
    f_mc_rq_stall = 0; f_mc_rs_vld = 0; f_mc_rs_cmd = '0; f_mc_rs_scmd = '0; f_mc_rs_data = '0;
    f_mc_rs_rtnctl = '0;
    repeat (3) @(negedge clk);
    check("rst_mc_rq_vld", mc_rq_vld, 0);
    check("rst_core_rq_stall", core_rq_stall, 0);
    check("rst_core_rs_vld", core_rs_vld, 0);
    check("rst_err", o_err_bad_id, 0);
    check("rst_total_stalls", o_total_stalls, 0);
    check("rst_rtnctl", mc_rq_rtnctl, 0);
    check("rst_rs_tag", core_rs_tag, 0);
    i_reset = 0; f_reset = 0;
    @(negedge clk);

    // Single core: core 2 tags 0x10..0x12 back-to-back
    log_cyc.delete(); log_rt.delete();
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      core_rq_vld = '0; push8(2, 16'h10 + 16'(i));
      @(negedge clk);
    end
    core_rq_vld = '0;
    repeat (6) @(negedge clk);
    check("single_count", log_rt.size(), 3);
    for (int i = 0; i < 3; i++) if (i < log_rt.size()) begin
      check("single_rtnctl", log_rt[i], 32'h20010 + 32'(i));
      check("single_cycle", log_cyc[i], k + 3 + i);
    end

    // Fairness: fresh reset, every core holds two entries
    i_reset = 1; repeat (2) @(negedge clk); i_reset = 0;
    log_cyc.delete(); log_rt.delete();
    k = cyc;
    for (int c = 0; c < N; c++) push8(c, 16'h100 + 16'(c));
    @(negedge clk);
    for (int c = 0; c < N; c++) push8(c, 16'h200 + 16'(c));
    @(negedge clk);
    core_rq_vld = '0;
    repeat (22) @(negedge clk);
    check("fair_count", log_rt.size(), 16);
    for (int i = 0; i < 16; i++) if (i < log_rt.size()) begin
      check("fair_rtnctl", log_rt[i], 32'((i % 8) << 16) + 32'(((i / 8) + 1) * 256 + (i % 8)));
      check("fair_cycle", log_cyc[i], k + 3 + i);
    end

    // MC stall: 10 stalled cycles with cores 0 and 1 pushing
    log_cyc.delete(); log_rt.delete();
    push8(0, 16'h300); push8(1, 16'h310);
    @(negedge clk);
    mc_rq_stall = 1;
    push8(0, 16'h301); push8(1, 16'h311);
    for (int j = 2; j <= 11; j++) begin
      @(negedge clk);
      check("stall_mc_rq_vld", mc_rq_vld, 0);
      if (j == 2) begin
        check("stall_core_rq_stall_early", core_rq_stall[1:0], 2'b00);
        push8(0, 16'h302); push8(1, 16'h312);
      end else if (j == 3) begin
        check("stall_core_rq_stall", core_rq_stall[1:0], 2'b11);
        core_rq_vld = '0;
      end
    end
`ifdef MC_ARB_STATS_EN
    check("stall_total", o_total_stalls, 10);
`else
    check("stall_total", o_total_stalls, 0);
`endif
    mc_rq_stall = 0;
    repeat (12) @(negedge clk);
    check("stall_drain_count", log_rt.size(), 6);
    for (int i = 0; i < 6; i++) if (i < log_rt.size())
      check("stall_drain_rtnctl", log_rt[i], 32'((i % 2) << 16) + 32'h300 + 32'((i % 2) * 16 + i / 2));

    // Response routing
    mc_rs_vld = 1; mc_rs_rtnctl = 32'h0005_00AB; mc_rs_data = 64'hDEAD_BEEF_0000_0001;
    mc_rs_cmd = 3'd2; mc_rs_scmd = 4'd1; core_rs_stall = 8'h08;
    @(negedge clk);
    mc_rs_vld = 0;
    check("rs_vld", core_rs_vld, 8'b0010_0000);
    check("rs_tag", core_rs_tag, 16'h00AB);
    check("rs_data", core_rs_data, 64'hDEAD_BEEF_0000_0001);
    check("rs_stall", mc_rs_stall, 1);
    core_rs_stall = '0;
    @(negedge clk);
    check("rs_vld_clear", core_rs_vld, 0);
    mc_rs_vld = 1; mc_rs_rtnctl = 32'h000C_0001;
    @(negedge clk);
    mc_rs_vld = 0;
    check("bad8_vld", core_rs_vld, 0);
    check("bad8_err", o_err_bad_id, 1);

    // 4-core instance: routing, bad id, reset flush
    f_mc_rs_vld = 1; f_mc_rs_rtnctl = 32'h0002_0033;
    @(negedge clk);
    check("f_rs_vld", f_core_rs_vld, 4'b0100);
    check("f_rs_tag", f_core_rs_tag, 16'h0033);
    f_mc_rs_rtnctl = 32'h0006_0000;
    @(negedge clk);
    f_mc_rs_vld = 0;
    check("f_bad_vld", f_core_rs_vld, 0);
    check("f_bad_err", f_o_err_bad_id, 1);
    f_log_rt.delete();
    push4(1, 16'h41);
    @(negedge clk);
    f_core_rq_vld = '0;
    repeat (5) @(negedge clk);
    check("f_err_sticky", f_o_err_bad_id, 1);
    check("f_pre_count", f_log_rt.size(), 1);
    if (f_log_rt.size() > 0) check("f_pre_rtnctl", f_log_rt[0], 32'h0001_0041);
    f_mc_rq_stall = 1;
    for (int i = 0; i < 3; i++) begin
      push4(3, 16'h51 + 16'(i));
      @(negedge clk);
    end
    f_core_rq_vld = '0;
    @(negedge clk);
    check("f_core3_stall", f_core_rq_stall[3], 1);
    f_reset = 1;
    @(negedge clk);
    f_reset = 0; f_mc_rq_stall = 0;
    check("f_rst_stall", f_core_rq_stall, 0);
    check("f_rst_err", f_o_err_bad_id, 0);
    f_log_rt.delete();
    repeat (4) begin
      @(negedge clk);
      check("f_flushed_idle", f_mc_rq_vld, 0);
    end
    for (int c = 0; c < 4; c++) push4(c, 16'h60 + 16'(c));
    @(negedge clk);
    f_core_rq_vld = '0;
    repeat (8) @(negedge clk);
    check("f_post_count", f_log_rt.size(), 4);
    for (int i = 0; i < 4; i++) if (i < f_log_rt.size())
      check("f_post_rtnctl", f_log_rt[i], 32'(i << 16) + 32'h60 + 32'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mc_port_arbiter.md
# mc_port_arbiter

Request arbiter and response router between the phold event-processing cores and a single memory-controller port. It buffers per-core MC requests, grants them round-robin onto the MC request interface while honouring `mc_rq_stall`, and tags each request so its response can be routed back to the issuing core. It sits directly downstream of the phold cores and directly upstream of the MC port driven out of `cae_pers`.

## Interface

Parameters:
- `NUM_CORES`, 8: number of requesting cores; power of two, 2..16.
- `ID_W`, 3: core-id width; equals log2(`NUM_CORES`).
- `TAG_W`, 16: core-local tag width.
- `RTNCTL_WIDTH`, 32: MC return-control width; must be at least `ID_W`+`TAG_W`.
- `FIFO_DEPTH`, 4: per-core request FIFO depth; power of two, at least 4.

Ports:
- `clk`  in  1  personality clock.
- `i_reset`  in  1  reset.
- `core_rq_vld`  in  `NUM_CORES`  per-core request valid.
- `core_rq_cmd`  in  `NUM_CORES`*3  MC command.
- `core_rq_scmd`  in  `NUM_CORES`*4  MC sub-command.
- `core_rq_size`  in  `NUM_CORES`*2  access size.
- `core_rq_vadr`  in  `NUM_CORES`*48  virtual address.
- `core_rq_data`  in  `NUM_CORES`*64  write data.
- `core_rq_tag`  in  `NUM_CORES`*`TAG_W`  core-local tag.
- `core_rq_stall`  out  `NUM_CORES`  per-core back-pressure.
- `core_rs_vld`  out  `NUM_CORES`  per-core response valid.
- `core_rs_cmd`  out  3  response command, shared by all cores.
- `core_rs_scmd`  out  4  response sub-command, shared.
- `core_rs_data`  out  64  response data, shared.
- `core_rs_tag`  out  `TAG_W`  response tag, shared.
- `core_rs_stall`  in  `NUM_CORES`  per-core response back-pressure.
- `mc_rq_vld`, `mc_rq_cmd`, `mc_rq_scmd`, `mc_rq_size`, `mc_rq_vadr`, `mc_rq_data`, `mc_rq_rtnctl`  out  1/3/4/2/48/64/`RTNCTL_WIDTH`  MC request.
- `mc_rq_stall`  in  1  MC back-pressure.
- `mc_rs_vld`, `mc_rs_cmd`, `mc_rs_scmd`, `mc_rs_data`, `mc_rs_rtnctl`  in  1/3/4/64/`RTNCTL_WIDTH`  MC response.
- `mc_rs_stall`  out  1  response back-pressure to the MC.
- `o_err_bad_id`  out  1  sticky flag: response carried an illegal core id.
- `o_total_stalls`  out  64  count of stalled arbitration cycles.

Reset is synchronous, active-high, on `i_reset`. All logic is clocked on `clk`.

## Operation

**Per-core FIFOs**
- Each core has one FIFO of `FIFO_DEPTH` entries holding {cmd, scmd, size, vadr, data, tag}.
- A FIFO is written on every cycle its `core_rq_vld` is high.
- `core_rq_stall[i]` is registered and is high when count[i] ≥ `FIFO_DEPTH`-2.
- This gives two entries of skid, which covers the stall latency.
- A write to a full FIFO is dropped. This can only happen if a core ignores its stall; verification treats it as a protocol violation.

**Arbiter**
- Round-robin pointer `last`; the search for the next grant starts at `last`+1 and wraps modulo `NUM_CORES`.
- A grant happens when `mc_rq_stall` is low and at least one FIFO is non-empty. The chosen FIFO pops and `last` becomes the chosen id.
- While `mc_rq_stall` is high there are no grants, and `mc_rq_vld` is 0 in the following cycle.

**Request output**
- All request fields are registered.
- `mc_rq_rtnctl` is formed as: zeros, then core id, then tag. The tag occupies bits [`TAG_W`-1:0] and the core id occupies the `ID_W` bits immediately above it.

**Response router**
- The core id is decoded from `mc_rs_rtnctl`.
- On `mc_rs_vld`, `core_rs_vld[id]` is asserted one cycle later. Cmd, scmd, data and tag are registered and shared by all cores.
- If id ≥ `NUM_CORES`, the response is dropped and `o_err_bad_id` is set. It stays set until reset.
- `mc_rs_stall` is the registered OR of `core_rs_stall`.
- Responses that arrive while `mc_rs_stall` is asserting are still delivered. Cores must therefore absorb up to 2 responses after raising their stall.

**Reset**
- Reset flushes all FIFOs.
- `last` resets to `NUM_CORES`-1, so core 0 has first priority.
- Requests in flight at the MC are not recalled. Their responses are still routed normally.

## Timing

- Reset values of outputs:
  - `core_rq_stall`, `core_rs_vld`, `mc_rq_vld`, `mc_rs_stall`, `o_err_bad_id` are all 0.
  - `o_total_stalls` is 0.
  - All data and tag outputs are 0.
- Request latency: a request written at edge t appears as `mc_rq_vld` at edge t+2 at the earliest, when there is no contention and no stall.
- Throughput: one grant per cycle while the MC is not stalling.
- Response latency: 1 cycle from `mc_rs_vld` to `core_rs_vld`.
- `core_rq_stall` asserts 1 cycle after the count reaches `FIFO_DEPTH`-2.
- A simultaneous push and pop on the same FIFO leaves its count unchanged.

## Configuration

- `MC_ARB_STATS_EN` defined:
  - `o_total_stalls` increments each cycle in which `mc_rq_stall` is high and any FIFO is non-empty.
  - It saturates at 2^64-1.
  - It clears on reset.
- `MC_ARB_STATS_EN` undefined: `o_total_stalls` is tied to 0 and the counter logic is removed.

## Test plan

- **Single core:** core 2 issues tags 0x10, 0x11, 0x12 back-to-back, no stall.
  - Expect `mc_rq_vld` on 3 consecutive cycles, the first 2 cycles after the first request.
  - Expect `mc_rq_rtnctl` = 0x20010, 0x20011, 0x20012.
- **Fairness:** all 8 cores keep their FIFOs non-empty.
  - Expect grant order 0,1,…,7,0,…
  - Expect no core to wait more than 8 grant cycles.
- **MC stall:** `mc_rq_stall` held for 10 cycles while cores 0 and 1 push requests.
  - Expect `mc_rq_vld` to be 0 from the second stall cycle onward.
  - Expect `core_rq_stall[0]` and `core_rq_stall[1]` high once each count reaches 2.
  - Expect no request to be lost.
  - With the macro defined, expect `o_total_stalls` = 10.
- **Response routing:** `mc_rs_rtnctl` = 0x5_00AB.
  - Expect `core_rs_vld` = 8'b0010_0000 and `core_rs_tag` = 0x00AB, one cycle later.
- **Bad id and reset:** build with `NUM_CORES`=4, then send a response with core id 6.
  - Expect the response dropped and `o_err_bad_id` = 1.
  - Then assert `i_reset` with core 3's FIFO holding 3 entries. Expect all FIFOs empty, `o_err_bad_id` = 0, and core 0 granted first afterwards.
